// File: rtl/imips_pkg.sv
// Shared constants for the ULAS ALU issue controller: ALU control codes, opcode/funct
// values, operand-2 source select and FSM state encodings.
package imips_pkg;

  localparam logic [4:0] ALU_PASS = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_NOT  = 5'b00101;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SLT  = 5'b01001;
  localparam logic [4:0] ALU_BEQ  = 5'b01011;
  localparam logic [4:0] ALU_BNE  = 5'b01100;
  localparam logic [4:0] ALU_BGE  = 5'b01110;
  localparam logic [4:0] ALU_LUI  = 5'b01111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_BLT   = 6'h06;
  localparam logic [5:0] OPC_BGE   = 6'h07;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOT = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] OP2_RT   = 2'd0;
  localparam logic [1:0] OP2_SEXT = 2'd1;
  localparam logic [1:0] OP2_ZEXT = 2'd2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational instruction decoder: maps opcode/funct to ALU control, operand-2 source,
// destination register and the completion-record attributes.
module alu_issue_dec
  import imips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [5:0]        opc_i,
  input  logic [5:0]        fn_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic [4:0]        aluop_o,
  output logic [1:0]        op2_sel_o,
  output logic              use_sh_o,
  output logic              wr_due_o,
  output logic [REG_AW-1:0] dest_o,
  output logic              is_slt_o,
  output logic              is_branch_o,
  output logic              ovf_chk_o,
  output logic              illegal_o
);

  always_comb begin
    aluop_o     = ALU_PASS;
    op2_sel_o   = OP2_RT;
    use_sh_o    = 1'b0;
    wr_due_o    = 1'b0;
    dest_o      = rd_i;
    is_slt_o    = 1'b0;
    is_branch_o = 1'b0;
    ovf_chk_o   = 1'b0;
    illegal_o   = 1'b0;
    case (opc_i)
      OPC_RTYPE: begin
        wr_due_o = 1'b1;
        case (fn_i)
          FN_ADD: begin aluop_o = ALU_ADD; ovf_chk_o = 1'b1; end
          FN_SUB: begin aluop_o = ALU_SUB; ovf_chk_o = 1'b1; end
          FN_AND: aluop_o = ALU_AND;
          FN_OR:  aluop_o = ALU_OR;
          FN_NOT: aluop_o = ALU_NOT;
          FN_XOR: aluop_o = ALU_XOR;
          FN_SLL: begin aluop_o = ALU_SLL; use_sh_o = 1'b1; end
          FN_SRL: begin aluop_o = ALU_SRL; use_sh_o = 1'b1; end
          FN_SLT: begin aluop_o = ALU_SLT; is_slt_o = 1'b1; end
          default: begin
            wr_due_o  = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OPC_ADDI: begin
        aluop_o = ALU_ADD; op2_sel_o = OP2_SEXT; ovf_chk_o = 1'b1;
        dest_o  = rt_i;    wr_due_o  = 1'b1;
      end
      OPC_ANDI: begin aluop_o = ALU_AND; op2_sel_o = OP2_ZEXT; dest_o = rt_i; wr_due_o = 1'b1; end
      OPC_ORI:  begin aluop_o = ALU_OR;  op2_sel_o = OP2_ZEXT; dest_o = rt_i; wr_due_o = 1'b1; end
      OPC_XORI: begin aluop_o = ALU_XOR; op2_sel_o = OP2_ZEXT; dest_o = rt_i; wr_due_o = 1'b1; end
      OPC_LUI:  begin aluop_o = ALU_LUI; op2_sel_o = OP2_ZEXT; dest_o = rt_i; wr_due_o = 1'b1; end
      OPC_BEQ:  begin aluop_o = ALU_BEQ; is_branch_o = 1'b1; end
      OPC_BNE:  begin aluop_o = ALU_BNE; is_branch_o = 1'b1; end
      OPC_BLT:  begin aluop_o = ALU_SLT; is_branch_o = 1'b1; end
      OPC_BGE:  begin aluop_o = ALU_BGE; is_branch_o = 1'b1; end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/control FSM driving the ULAS ALU: IDLE -> READ -> EXEC -> DONE, with register
// writeback or branch resolution reported through a valid/ready completion record.
module alu_issue_ctrl
  import imips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc_in,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [4:0]        alu_smt,
  output logic [4:0]        alu_aluop,
  input  logic [DATA_W-1:0] alu_r1,
  input  logic              alu_uf,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              br_taken,
  output logic [31:0]       br_target,
  output logic              exc_ovf,
  output logic              exc_ill
);

  logic [1:0]        state_q, state_d;
  logic [5:0]        opc_q, opc_d;
  logic [20:0]       fld_q, fld_d;   // instr[20:0]; rs is only needed at accept time
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, r1_q, r1_d;
  logic [4:0]        smt_q, smt_d;
  logic              uf_q, uf_d;

  logic [4:0]        dec_aluop;
  logic [1:0]        dec_op2_sel;
  logic              dec_use_sh, dec_wr_due, dec_is_slt, dec_is_branch, dec_ovf_chk, dec_illegal;
  logic [REG_AW-1:0] dec_dest;
  logic              wr_ok;

  alu_issue_dec #(.REG_AW(REG_AW)) u_dec (
    .opc_i       (opc_q),
    .fn_i        (fld_q[5:0]),
    .rt_i        (fld_q[16 +: REG_AW]),
    .rd_i        (fld_q[11 +: REG_AW]),
    .aluop_o     (dec_aluop),
    .op2_sel_o   (dec_op2_sel),
    .use_sh_o    (dec_use_sh),
    .wr_due_o    (dec_wr_due),
    .dest_o      (dec_dest),
    .is_slt_o    (dec_is_slt),
    .is_branch_o (dec_is_branch),
    .ovf_chk_o   (dec_ovf_chk),
    .illegal_o   (dec_illegal)
  );

  // Overflowing arithmetic and writes to r0 never reach the register file.
  assign wr_ok = dec_wr_due && !(dec_ovf_chk && uf_q) && (dec_dest != '0);

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    fld_d       = fld_q;
    pc_d        = pc_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    smt_d       = smt_q;
    r1_d        = r1_q;
    uf_d        = uf_q;
    instr_ready = 1'b0;
    rf_ra1      = '0;
    rf_ra2      = '0;
    alu_op1     = '0;
    alu_op2     = '0;
    alu_smt     = '0;
    alu_aluop   = ALU_PASS;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    done_valid  = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
    exc_ovf     = 1'b0;
    exc_ill     = 1'b0;
    case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          rf_ra1  = instr[21 +: REG_AW];
          rf_ra2  = instr[16 +: REG_AW];
          opc_d   = instr[31:26];
          fld_d   = instr[20:0];
          pc_d    = pc_in;
          state_d = StRead;
        end
      end
      StRead: begin
        op1_d = rf_rd1;
        case (dec_op2_sel)
          OP2_SEXT: op2_d = {{(DATA_W-16){fld_q[15]}}, fld_q[15:0]};
          OP2_ZEXT: op2_d = {{(DATA_W-16){1'b0}}, fld_q[15:0]};
          default:  op2_d = rf_rd2;
        endcase
        smt_d   = dec_use_sh ? fld_q[10:6] : 5'd0;
        r1_d    = '0;
        uf_d    = 1'b0;
        state_d = dec_illegal ? StDone : StExec;
      end
      StExec: begin
        alu_op1   = op1_q;
        alu_op2   = op2_q;
        alu_smt   = smt_q;
        alu_aluop = dec_aluop;
        r1_d      = alu_r1;
        uf_d      = alu_uf;
        state_d   = StDone;
      end
      default: begin
        done_valid = 1'b1;
        exc_ill    = dec_illegal;
        exc_ovf    = dec_ovf_chk & uf_q;
        br_taken   = dec_is_branch & uf_q;
        if (dec_is_branch) begin
          br_target = pc_q + 32'd4 + {{14{fld_q[15]}}, fld_q[15:0], 2'b00};
        end
        if (wr_ok) begin
          rf_wa = dec_dest;
          rf_wd = dec_is_slt ? {{(DATA_W-1){1'b0}}, uf_q} : r1_q;
        end
        if (done_ready) begin
          rf_we   = wr_ok;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      opc_q   <= '0;
      fld_q   <= '0;
      pc_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      smt_q   <= '0;
      r1_q    <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      fld_q   <= fld_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      smt_q   <= smt_d;
      r1_q    <= r1_d;
      uf_q    <= uf_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: register-file and ALU models around the DUT,
// instruction-level reference model feeding an expectation queue, independent monitor.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        br_taken;
    logic        is_br;
    logic [31:0] br_target;
    logic        ovf;
    logic        ill;
    logic [4:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        is_sh;
    logic [4:0]  smt;
  } exp_t;

  localparam logic [5:0]  FN_TAB [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h00,
                                         6'h02, 6'h2A};
  localparam logic [5:0]  OP_TAB [5] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  localparam logic [31:0] EDGE   [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};

  logic        clk, rst;
  logic        instr_valid, instr_ready, done_valid, done_ready;
  logic [31:0] instr, pc_in, br_target;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa, alu_smt, alu_aluop;
  logic [31:0] rf_rd1, rf_rd2, alu_op1, alu_op2, alu_r1, rf_wd, alu_t;
  logic        alu_uf, rf_we, br_taken, exc_ovf, exc_ill;
  logic        poke_en;
  logic [4:0]  poke_a;
  logic [31:0] poke_d;
  logic [31:0] rf_mem   [32];
  logic [31:0] ref_regs [32];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_err = 0;

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_in(pc_in), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_smt(alu_smt),
    .alu_aluop(alu_aluop), .alu_r1(alu_r1), .alu_uf(alu_uf), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .done_valid(done_valid), .done_ready(done_ready), .br_taken(br_taken),
    .br_target(br_target), .exc_ovf(exc_ovf), .exc_ill(exc_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with synchronous read; bench pokes take priority over DUT writes.
  always @(posedge clk) begin
    rf_rd1 <= rf_mem[rf_ra1];
    rf_rd2 <= rf_mem[rf_ra2];
    if (poke_en) rf_mem[poke_a] <= poke_d;
    else if (rf_we) rf_mem[rf_wa] <= rf_wd;
  end

  // ALU environment model.
  always_comb begin
    alu_t  = alu_op2;
    alu_uf = 1'b0;
    case (alu_aluop)
      5'd1: begin
        alu_t  = alu_op1 + alu_op2;
        alu_uf = (alu_op1[31] == alu_op2[31]) && (alu_t[31] != alu_op1[31]);
      end
      5'd2: begin
        alu_t  = alu_op1 - alu_op2;
        alu_uf = (alu_op1[31] != alu_op2[31]) && (alu_t[31] != alu_op1[31]);
      end
      5'd3:  alu_t = alu_op1 & alu_op2;
      5'd4:  alu_t = alu_op1 | alu_op2;
      5'd5:  alu_t = ~alu_op1;
      5'd6:  alu_t = alu_op1 ^ alu_op2;
      5'd7:  alu_t = alu_op2 << alu_smt;
      5'd8:  alu_t = alu_op2 >> alu_smt;
      5'd9:  begin alu_uf = alu_op1 < alu_op2;  alu_t = {31'b0, alu_uf}; end
      5'd11: alu_uf = alu_op1 == alu_op2;
      5'd12: alu_uf = alu_op1 != alu_op2;
      5'd14: alu_uf = alu_op1 >= alu_op2;
      5'd15: alu_t = alu_op2 << 16;
      default: alu_t = alu_op2;
    endcase
    alu_r1 = alu_t;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic ovf32(input longint s);
    return s != longint'($signed(s[31:0]));
  endfunction

  // Instruction-level semantics against the bench's architectural register copy.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] a, b, sx, zx;
    logic [4:0]  dst;
    logic        wr;
    e   = '0;
    a   = ref_regs[ins[25:21]];
    b   = ref_regs[ins[20:16]];
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'h0, ins[15:0]};
    dst = ins[15:11];
    wr  = 1'b0;
    e.op1 = a;
    e.op2 = b;
    case (ins[31:26])
      6'h00: begin
        wr = 1'b1;
        case (ins[5:0])
          6'h20: begin e.aluop = 5'd1; e.wd = a + b;
                       e.ovf = ovf32(longint'($signed(a)) + longint'($signed(b))); end
          6'h22: begin e.aluop = 5'd2; e.wd = a - b;
                       e.ovf = ovf32(longint'($signed(a)) - longint'($signed(b))); end
          6'h24: begin e.aluop = 5'd3; e.wd = a & b; end
          6'h25: begin e.aluop = 5'd4; e.wd = a | b; end
          6'h27: begin e.aluop = 5'd5; e.wd = ~a; end
          6'h26: begin e.aluop = 5'd6; e.wd = a ^ b; end
          6'h00: begin e.aluop = 5'd7; e.wd = b << ins[10:6]; e.is_sh = 1; e.smt = ins[10:6]; end
          6'h02: begin e.aluop = 5'd8; e.wd = b >> ins[10:6]; e.is_sh = 1; e.smt = ins[10:6]; end
          6'h2A: begin e.aluop = 5'd9; e.wd = (a < b) ? 32'd1 : 32'd0; end
          default: begin e.ill = 1'b1; wr = 1'b0; end
        endcase
      end
      6'h08: begin e.aluop = 5'd1; e.op2 = sx; e.wd = a + sx; wr = 1; dst = ins[20:16];
                   e.ovf = ovf32(longint'($signed(a)) + longint'($signed(sx))); end
      6'h0C: begin e.aluop = 5'd3;  e.op2 = zx; e.wd = a & zx;   wr = 1; dst = ins[20:16]; end
      6'h0D: begin e.aluop = 5'd4;  e.op2 = zx; e.wd = a | zx;   wr = 1; dst = ins[20:16]; end
      6'h0E: begin e.aluop = 5'd6;  e.op2 = zx; e.wd = a ^ zx;   wr = 1; dst = ins[20:16]; end
      6'h0F: begin e.aluop = 5'd15; e.op2 = zx; e.wd = zx << 16; wr = 1; dst = ins[20:16]; end
      6'h04: begin e.aluop = 5'd11; e.is_br = 1; e.br_taken = (a == b); end
      6'h05: begin e.aluop = 5'd12; e.is_br = 1; e.br_taken = (a != b); end
      6'h06: begin e.aluop = 5'd9;  e.is_br = 1; e.br_taken = (a < b);  end
      6'h07: begin e.aluop = 5'd14; e.is_br = 1; e.br_taken = (a >= b); end
      default: e.ill = 1'b1;
    endcase
    if (e.is_br) e.br_target = pc + 32'd4 + (sx << 2);
    e.wa = dst;
    e.we = wr && !e.ovf && (dst != 5'd0);
    return e;
  endfunction

  task automatic set_reg(input int r, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_a = 5'(r); poke_d = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_regs[r] = v;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input int stall);
    exp_t e;
    int   lat;
    e = ref_model(ins, pc);
    exp_q.push_back(e);
    if (e.we) ref_regs[e.wa] = e.wd;
    @(posedge clk); #1;
    chk("idle_ready", 32'(instr_ready), 32'd1);
    done_ready  = (stall == 0);
    instr       = ins;
    pc_in       = pc;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    pc_in       = $urandom;
    chk("read_alu_idle", 32'(alu_aluop), 32'd0);
    chk("busy_not_ready", 32'(instr_ready), 32'd0);
    lat = 0;
    if (!e.ill) begin
      @(posedge clk); #1;
      lat = 1;
      chk("exec_aluop", 32'(alu_aluop), 32'(e.aluop));
      chk("exec_op1", alu_op1, e.op1);
      chk("exec_op2", alu_op2, e.op2);
      if (e.is_sh) chk("exec_smt", 32'(alu_smt), 32'(e.smt));
    end
    while (!done_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", 32'(lat), e.ill ? 32'd1 : 32'd2);
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      done_ready = 1'b1;
    end
    lat = 0;
    while (!instr_ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!instr_ready) begin
      n_err++;
      $display("FAIL return_idle: instr_ready=%0d after %0d cycles, want 1", instr_ready, lat);
    end
  endtask

  // Monitor: pops one expectation per completion handshake, checks record stability.
  initial begin : monitor
    exp_t        e;
    logic [71:0] snap, cur;
    logic        stall_seen;
    stall_seen = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_seen = 1'b0;
      end else begin
        cur = {rf_wa, rf_wd, br_taken, br_target, exc_ovf, exc_ill};
        if (rf_we && !(done_valid && done_ready)) begin
          n_err++;
          $display("FAIL rf_we_outside_handshake: got 1 want 0");
        end
        if (done_valid) begin
          if (stall_seen) begin
            n_checks++;
            if (cur !== snap) begin
              n_err++;
              $display("FAIL done_hold: got %h want %h", cur, snap);
            end
          end
          snap       = cur;
          stall_seen = !done_ready;
          if (done_ready) begin
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_done: got done_valid=1 want no completion");
            end else begin
              e = exp_q.pop_front();
              chk("rf_we", 32'(rf_we), 32'(e.we));
              if (e.we) begin
                chk("rf_wa", 32'(rf_wa), 32'(e.wa));
                chk("rf_wd", rf_wd, e.wd);
              end
              chk("br_taken", 32'(br_taken), 32'(e.br_taken));
              if (e.is_br) chk("br_target", br_target, e.br_target);
              chk("exc_ovf", 32'(exc_ovf), 32'(e.ovf));
              chk("exc_ill", 32'(exc_ill), 32'(e.ill));
            end
          end
        end else begin
          stall_seen = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ins, base;
    int          k, stall;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; pc_in = '0; done_ready = 1'b0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_aluop", 32'(alu_aluop), 32'd0);
    chk("rst_op2", alu_op2, 32'd0);
    chk("rst_exc_ill", 32'(exc_ill), 32'd0);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) set_reg(r, (r == 0) ? 32'd0 : $urandom);

    set_reg(1, 32'd5); set_reg(2, 32'd7);
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h0, 0);          // ADD r3
    set_reg(1, 32'h7FFFFFFF); set_reg(2, 32'd1);
    issue({6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h20}, 32'h4, 0);          // ADD overflow
    issue({6'h0F, 5'd0, 5'd4, 16'h1234}, 32'h8, 0);                    // LUI r4
    set_reg(1, 32'd9); set_reg(2, 32'd9);
    issue({6'h04, 5'd1, 5'd2, 16'hFFFE}, 32'h100, 0);                  // BEQ taken
    set_reg(2, 32'd8);
    issue({6'h04, 5'd1, 5'd2, 16'hFFFE}, 32'h100, 0);                  // BEQ not taken
    issue({6'h3F, 26'h155_5555}, 32'hC, 0);                            // illegal opcode
    issue({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h3F}, 32'h10, 0);          // illegal funct
    issue({6'h08, 5'd1, 5'd0, 16'h0005}, 32'h14, 0);                   // ADDI to r0
    issue({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h22}, 32'h18, 5);          // SUB, held done

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 5) == 0) set_reg($urandom_range(1, 31), EDGE[$urandom_range(0, 3)]);
      k    = $urandom_range(0, 19);
      base = $urandom;
      if (k < 9)       ins = {6'h00, base[25:6], FN_TAB[k]};
      else if (k < 14) ins = {OP_TAB[k-9], base[25:0]};
      else if (k < 18) ins = {6'h04 + 6'(k - 14), base[25:0]};
      else if (k == 18) ins = {6'($urandom_range(16, 63)), base[25:0]};
      else             ins = {6'h00, base[25:6], 6'($urandom_range(48, 63))};
      if (k >= 14 && k < 18 && $urandom_range(0, 3) == 0) ins[20:16] = ins[25:21];
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      issue(ins, $urandom, stall);
    end

    // Reset in EXEC drops the in-flight ADD r5.
    set_reg(1, 32'd10); set_reg(2, 32'd20); set_reg(5, 32'hA5A5_0005);
    @(posedge clk); #1;
    done_ready = 1'b1; instr = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_exec_aluop", 32'(alu_aluop), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_exec_ready", 32'(instr_ready), 32'd1);
    chk("rst_exec_done", 32'(done_valid), 32'd0);
    chk("rst_exec_rf_we", 32'(rf_we), 32'd0);
    chk("rst_exec_aluop", 32'(alu_aluop), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 32'(done_valid), 32'd0);
    end
    chk("post_rst_r5", rf_mem[5], ref_regs[5]);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/control FSM that drives the ULAS ALU.
- Accepts one decoded-to-be instruction per handshake and reads two operands from the register file.
- Builds op1/op2/smt/aluop for the ALU, then captures r1/UF.
- Performs register writeback or branch resolution and reports completion; it is the producer side of the ALU interface.

Parameters:
- DATA_W, 32, datapath width; must match the ALU.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  FSM can accept
- instr  in  32  instruction word
- pc_in  in  32  PC of instr
- rf_ra1, rf_ra2  out  REG_AW  register-file read addresses (rs, rt)
- rf_rd1, rf_rd2  in  DATA_W  read data; synchronous, valid one cycle after address
- alu_op1, alu_op2  out  DATA_W  ALU operands
- alu_smt  out  5  shift amount
- alu_aluop  out  5  ALU control code
- alu_r1  in  DATA_W  ALU result
- alu_uf  in  1  ALU flag
- rf_we  out  1  write enable
- rf_wa  out  REG_AW  write address
- rf_wd  out  DATA_W  write data
- done_valid  out  1  completion record valid
- done_ready  in  1  completion consumer ready
- br_taken  out  1  branch taken (qualified by done_valid)
- br_target  out  32  branch target
- exc_ovf  out  1  overflow trap; writeback suppressed
- exc_ill  out  1  illegal opcode/funct

Behaviour:
- Reset: state IDLE; instr_ready=1; every other output 0, including alu_aluop=00000 (ALU passes op2).
- Decode fields: opc=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0], imm=[15:0].
- R-type (opc 00), write to rd:
  - fn 20 ADD → 00001
  - fn 22 SUB → 00010
  - fn 24 AND → 00011
  - fn 25 OR → 00100
  - fn 27 NOT → 00101
  - fn 26 XOR → 00110
  - fn 00 SLL → 00111 (smt=sh)
  - fn 02 SRL → 01000 (smt=sh)
  - fn 2A SLT → 01001; rf_wd={31'b0,UF}
- I-type, write to rt, op2=imm:
  - 08 ADDI → 00001 (imm sign-extended)
  - 0C ANDI → 00011, 0D ORI → 00100, 0E XORI → 00110 (imm zero-extended)
  - 0F LUI → 01111 (imm zero-extended)
- Branches, no write:
  - 04 BEQ → 01011
  - 05 BNE → 01100
  - 06 BLT → 01001
  - 07 BGE → 01110
  - Comparisons are unsigned, as the ALU defines them. br_taken=UF.
  - br_target = pc_in + 4 + (sext(imm)<<2), modulo 2^32.
- Any other opc/fn: exc_ill=1, no rf write, no ALU use.
- FSM IDLE→READ→EXEC→DONE→IDLE:
  - IDLE: instr_ready=1. On instr_valid, latch instr/pc_in and drive rf_ra1=rs, rf_ra2=rt; go to READ.
  - READ: capture rf_rd1/rf_rd2 into operand registers. Illegal instructions skip to DONE with exc_ill.
  - EXEC: drive the registered ALU inputs and capture alu_r1/alu_uf at the clock edge.
  - ADD/SUB/ADDI with UF=1: set exc_ovf and suppress the write.
  - DONE: done_valid=1 and hold all record fields stable until done_ready.
  - On the done_valid&done_ready cycle: rf_we=1 (single cycle) if a write is due and the destination is nonzero; return to IDLE.
- Latency: accept at edge 0; done_valid is high from cycle 3 (min 3 cycles accept→done). instr_ready is low from READ through DONE.
- Write to register 0 is never issued (rf_we stays 0).
- alu_* outputs return to 0 outside EXEC so the ALU idles in default pass-through.
- done_ready held low: stays in DONE indefinitely, no duplicate rf_we.
- Reset asserted in any state: immediate return to IDLE; an in-flight instruction is dropped with no rf_we and no done_valid.

Decomposition:
- Package imips_pkg holds:
  - aluop localparams (ALU_ADD=5'b00001 … ALU_LUI=5'b01111, ALU_PASS=5'b00000)
  - opcode/funct constants
  - FSM state enum
- One sub-module, alu_issue_dec: purely combinational (instr → aluop, imm mode, dest select, is_branch, is_ovf_checked, illegal). The FSM and registers live in alu_issue_ctrl.

Test Plan:
- ADD r3=r1+r2, r1=5, r2=7 → alu_aluop=00001 in EXEC; done at cycle 3 with rf_we=1, rf_wa=3, rf_wd=12.
- ADD with r1=0x7FFFFFFF, r2=1 → exc_ovf=1, rf_we=0, done_valid=1.
- LUI r4,0x1234 → alu_op2=0x00001234, aluop=01111; rf_wd=0x12340000, rf_wa=4.
- BEQ r1,r2,imm=-2, pc_in=0x100, r1=r2=9 → br_taken=1, br_target=0x000000FC, rf_we=0. Repeat with r2=8 → br_taken=0.
- Opcode 0x3F → exc_ill=1 after 2 cycles, no rf_we. Separately, ADDI targeting r0 → done_valid with rf_we=0.
- done_ready held low 5 cycles, then high → fields stable and rf_we exactly one cycle. Reset pulsed during EXEC → instr_ready=1, no done_valid, no rf_we.
